// File: rtl/fp_pkg.sv
// Shared constants for the floating-point normalize slice.
// Default widths, all-ones exponent and shift-count width helper.
package fp_pkg;

  localparam int MANT_W_DEF = 24;
  localparam int EXP_W_DEF  = 8;

  localparam int SHIFT_W_DEF = $clog2(MANT_W_DEF);

  localparam logic [EXP_W_DEF-1:0] EXP_ONES = '1;

  function automatic int shift_w(input int mant_w);
    return (mant_w > 1) ? $clog2(mant_w) : 1;
  endfunction

endpackage

// File: rtl/lz_count.sv
// Leading-one finder: distance of the top set bit from the MSB.
// Purely combinational; zero flags an all-zero input.
module lz_count
  import fp_pkg::*;
#(
  parameter int W  = MANT_W_DEF,
  parameter int CW = shift_w(W)
) (
  input  logic [W-1:0]  d,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    cnt  = '0;
    zero = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (d[i]) begin
        cnt  = CW'(W - 1 - i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_normalize.sv
// Two-stage normalizer for raw adder results (carry, shift, flush).
// S1 captures the beat and its shift count; S2 holds the result.
module fp_normalize
  import fp_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W  = EXP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W:0]   in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-2:0] out_frac,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              out_unf
);

  localparam int SW = shift_w(MANT_W);
  localparam int XW = EXP_W + SW + 1;

  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W:0]   mant;
    logic [SW-1:0]     sh;
    logic              lz;
  } s1_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-2:0] frac;
    logic              zero;
    logic              ovf;
    logic              unf;
  } s2_t;

  logic          s1_valid;
  logic          s2_valid;
  logic          en1;
  logic          en2;
  s1_t           s1_d;
  s1_t           s1_q;
  s2_t           s2_d;
  s2_t           s2_q;
  logic [SW-1:0] lz_sh;
  logic          lz_zero;

  logic              carry;
  logic              is_zero;
  logic              is_unf;
  logic              is_norm;
  logic [EXP_W:0]    exp_inc;
  logic [XW-1:0]     exp_x;
  logic [XW-1:0]     sh_x;
  logic [MANT_W-1:0] mant_l;

  lz_count #(
    .W  (MANT_W),
    .CW (SW)
  ) u_lz (
    .d    (in_mant[MANT_W-1:0]),
    .cnt  (lz_sh),
    .zero (lz_zero)
  );

  assign en2      = ~s2_valid | out_ready;
  assign en1      = ~s1_valid | en2;
  assign in_ready = en1 & ~rst;

  assign s1_d = '{
    sign: in_sign,
    exp:  in_exp,
    mant: in_mant,
    sh:   lz_sh,
    lz:   lz_zero
  };

  assign carry   = s1_q.mant[MANT_W];
  assign exp_inc = {1'b0, s1_q.exp} + (EXP_W+1)'(1);
  assign exp_x   = XW'(s1_q.exp);
  assign sh_x    = XW'(s1_q.sh);
  assign mant_l  = s1_q.mant[MANT_W-1:0] << s1_q.sh;

  assign is_zero = ~carry & s1_q.lz;
  assign is_unf  = ~carry & ~s1_q.lz & (exp_x <= sh_x);
  assign is_norm = ~carry & ~s1_q.lz & (exp_x > sh_x);

  // Pick carry, zero, flush or left-normalize for the S1 beat.
  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    unique case (1'b1)
      carry: begin
        if (exp_inc >= {1'b0, EXP_MAX}) begin
          s2_d.ovf = 1'b1;
          s2_d.exp = EXP_MAX;
        end else begin
          s2_d.exp  = exp_inc[EXP_W-1:0];
          s2_d.frac = s1_q.mant[MANT_W-1:1];
        end
      end
      is_zero: s2_d.zero = 1'b1;
      is_unf:  s2_d.unf  = 1'b1;
      is_norm: begin
        s2_d.exp  = s1_q.exp - EXP_W'(s1_q.sh);
        s2_d.frac = mant_l[MANT_W-2:0];
      end
      default: s2_d = '0;
    endcase
  end

  // Advance both stages under their enables; reset flushes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (en1) s1_valid <= in_valid;
      if (en1 & in_valid) s1_q <= s1_d;
      if (en2) s2_valid <= s1_valid;
      if (en2 & s1_valid) s2_q <= s2_d;
    end
  end

  assign out_valid = s2_valid;
  assign out_sign  = s2_q.sign;
  assign out_exp   = s2_q.exp;
  assign out_frac  = s2_q.frac;
  assign out_zero  = s2_q.zero;
  assign out_ovf   = s2_q.ovf;
  assign out_unf   = s2_q.unf;

endmodule

// File: tb/tb_fp_normalize.sv
// Scoreboard bench for fp_normalize against an arithmetic model.
// Directed corner beats, backpressure, reset flush, then random traffic.
module tb_fp_normalize;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_frac;
  logic        out_zero;
  logic        out_ovf;
  logic        out_unf;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic        zero;
    logic        ovf;
    logic        unf;
  } res_t;

  res_t act;
  res_t held;
  res_t q[$];
  int   tq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   ready_always = 1'b1;
  bit   stall_prev = 1'b0;

  assign act = {out_sign, out_exp, out_frac, out_zero, out_ovf, out_unf};

  fp_normalize #(
    .MANT_W (24),
    .EXP_W  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_frac  (out_frac),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t model(logic s, logic [7:0] e, logic [24:0] m);
    res_t   r;
    longint mm;
    int     p;
    int     sh;
    int     ev;
    r      = '0;
    r.sign = s;
    mm     = longint'(m);
    if (mm == 0) begin
      r.zero = 1'b1;
    end else if (mm >= 64'h1000000) begin
      ev = int'(e) + 1;
      if (ev >= 255) begin
        r.ovf = 1'b1;
        r.exp = 8'hFF;
      end else begin
        r.exp  = 8'(ev);
        r.frac = 23'((mm >> 1) - 64'h800000);
      end
    end else begin
      p = 0;
      while ((mm >> (p + 1)) != 0) p++;
      sh = 23 - p;
      if (int'(e) <= sh) begin
        r.unf = 1'b1;
      end else begin
        r.exp  = 8'(int'(e) - sh);
        r.frac = 23'((mm << sh) - 64'h800000);
      end
    end
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] a, logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, a, e, cyc);
    end
  endtask

  // Record every accepted beat with its model result.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      q.push_back(model(in_sign, in_exp, in_mant));
      tq.push_back(cyc);
    end
  end

  // Compare delivered beats and check stability under backpressure.
  always @(negedge clk) begin
    res_t e;
    int   t;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("hold", 64'({out_valid, act}), 64'({1'b1, held}));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got %h expected none", act);
        end else begin
          e = q.pop_front();
          t = tq.pop_front();
          chk("beat", 64'(act), 64'(e));
          if (ready_always)
            chk("latency", 64'(cyc - t), 64'(2));
          else
            chk("latency_min", 64'(cyc - t >= 2), 64'(1));
        end
      end
      stall_prev = out_valid && !out_ready;
      held = act;
    end
  end

  task automatic send(logic s, logic [7:0] e, logic [24:0] m);
    bit ok;
    ok       = 1'b0;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got no in_ready expected accept");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 64'(q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out", 64'({out_valid, act}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_valid", 64'(out_valid), 64'(0));
    chk("idle_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    send(1'b0, 8'h80, 25'h0800000);
    send(1'b0, 8'h80, 25'h1800000);
    send(1'b1, 8'h80, 25'h0000001);
    send(1'b0, 8'h10, 25'h0000001);
    send(1'b1, 8'h55, 25'h0000000);
    send(1'b0, 8'hFE, 25'h1000000);
    send(1'b1, 8'hFD, 25'h1FFFFFF);
    send(1'b0, 8'd23, 25'h0000001);
    send(1'b0, 8'd24, 25'h0000001);
    send(1'b1, 8'hFF, 25'h1000001);
    drain();

    ready_always = 1'b0;
    out_ready    = 1'b0;
    in_valid     = 1'b1;
    in_sign      = 1'b0;
    in_exp       = 8'h40;
    in_mant      = 25'h0123456;
    @(negedge clk);
    chk("bp_ready_a", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_sign = 1'b1;
    in_exp  = 8'h41;
    in_mant = 25'h1ABCDEF;
    @(negedge clk);
    chk("bp_ready_b", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_sign = 1'b0;
    in_exp  = 8'h42;
    in_mant = 25'h0000F00;
    repeat (3) begin
      @(negedge clk);
      chk("bp_full", 64'(in_ready), 64'(0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_release", 64'(out_valid), 64'(1));
      @(posedge clk);
      #1;
      if (k == 0) in_valid = 1'b0;
    end
    drain();

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_exp    = 8'h70;
    in_mant   = 25'h0400000;
    @(posedge clk);
    #1;
    in_mant = 25'h0200000;
    @(posedge clk);
    #1;
    in_mant = 25'h0100000;
    rst     = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    q.delete();
    tq.delete();
    @(negedge clk);
    chk("midrst_flush", 64'({out_valid, act}), 64'(0));
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_stale", 64'(out_valid), 64'(0));
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      in_sign   = 1'($urandom);
      case ($urandom_range(0, 4))
        0:       in_exp = 8'($urandom_range(0, 30));
        1:       in_exp = 8'($urandom_range(250, 255));
        default: in_exp = 8'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       in_mant = '0;
        1:       in_mant = 25'h1000000 | 25'($urandom);
        2:       in_mant = 25'($urandom);
        3:       in_mant = 25'(($urandom & 32'hFFFFFF) >> $urandom_range(0, 23));
        4:       in_mant = 25'(1) << $urandom_range(0, 24);
        default: in_mant = 25'($urandom) & 25'hFFFFFF;
      endcase
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_normalize.md
FP_NORMALIZE -- requirements
Module: fp_normalize

Interface
REQ-001 SHALL have parameter MANT_W, default 24, meaning significand width including hidden bit.
REQ-002 SHALL have parameter EXP_W, default 8, meaning biased exponent width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, input beat present.
REQ-006 SHALL have port in_ready, output, 1, input beat accepted when in_valid & in_ready.
REQ-007 SHALL have ports in_sign (input, 1) and in_exp (input, EXP_W): sign and biased exponent of the raw adder result.
REQ-008 SHALL have port in_mant, input, MANT_W+1; bit MANT_W is the adder carry-out.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): output handshake.
REQ-010 SHALL have ports out_sign (output, 1), out_exp (output, EXP_W) and out_frac (output, MANT_W-1): normalized result with hidden bit dropped.
REQ-011 SHALL have flag outputs out_zero, out_ovf and out_unf, each 1 bit: exact zero, exponent overflow and underflow flush.

Function
REQ-012 SHALL be a 2-stage pipeline: S1 registers the input plus leading-one shift count; S2 registers the shifted result and flags; latency exactly 2 cycles with no stall.
REQ-013 SHALL use enables en2 = ~s2_valid | out_ready, en1 = ~s1_valid | en2 and in_ready = en1 (combinational, no bubble at full throughput).
REQ-014 SHALL hold out_* stable while out_valid & ~out_ready; beats are never dropped, duplicated or reordered.
REQ-015 SHALL handle carry (in_mant[MANT_W]=1): shift right 1, truncate the LSB, exp+1.
REQ-016 SHALL set out_ovf=1, out_exp=all-ones and out_frac=0 when exp+1 >= 2^EXP_W-1.
REQ-017 SHALL handle no carry with mant nonzero: compute s = (MANT_W-1) - index of the most significant 1 in in_mant[MANT_W-1:0], shift left by s and set exp-s.
REQ-018 SHALL flush on underflow (in_exp <= s): out_unf=1, out_exp=0, out_frac=0.
REQ-019 SHALL handle mant zero (all MANT_W+1 bits): out_zero=1, out_exp=0, out_frac=0.
REQ-020 SHALL pass in_sign unchanged in all cases, including zero, overflow and underflow.
REQ-021 SHALL assert at most one of out_zero, out_ovf and out_unf.
REQ-022 SHALL produce no rounding; truncation only.
REQ-023 SHALL accept in_valid independently of out_ready and ignore in_* when in_valid=0.

Reset
REQ-024 SHALL, while rst=1 at a clock edge, clear s1_valid and s2_valid, set out_valid=0 and all out_* data and flags to 0.
REQ-025 SHALL force in_ready=0 during a reset cycle and SHALL take no beat in that cycle.
REQ-026 SHALL discard beats in flight when reset is asserted mid-operation; first output after reset comes from a beat accepted after reset.

Structure
REQ-027 SHALL place MANT_W/EXP_W defaults, the all-ones exponent constant and the shift-count width ($clog2(MANT_W)) in shared package fp_pkg.
REQ-028 SHALL implement leading-one position as sub-module lz_count (MANT_W-bit input, shift count plus all-zero flag, purely combinational), used in S1.
REQ-029 SHALL contain no latches, no multi-cycle paths and no second clock.

Verification
REQ-030 SHALL cover: in_mant=25'h0800000, exp=8'h80 -> 2 cycles later exp=8'h80, frac=0, no flags.
REQ-031 SHALL cover: in_mant=25'h1800000, exp=8'h80 -> exp=8'h81, frac=23'h400000.
REQ-032 SHALL cover: in_mant=25'h0000001 -> exp=8'h80 gives exp=8'h69, frac=0; exp=8'h10 gives out_unf=1, exp=0.
REQ-033 SHALL cover: in_mant=0, sign=1 -> out_zero=1, sign=1; in_mant=25'h1000000, exp=8'hFE -> out_ovf=1, exp=8'hFF, frac=0.
REQ-034 SHALL cover: 3 back-to-back beats with out_ready=0 -> in_ready drops after 2 accepted; on release outputs are the 3 beats in order, one per cycle.
REQ-035 SHALL cover: rst pulsed with both stages valid -> out_valid=0 next cycle, no stale beat emitted.
